// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: state encoding,
// default operand width and the round-robin wrap helper.
package mult_pkg;

  localparam int unsigned MULT_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Wraps v into [0, n) assuming v < 2*n.
  function automatic int unsigned rr_wrap(input int unsigned v, input int unsigned n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping modulo NUM_REQ. Outputs the one-hot winner and its index.
module rr_pick
  import mult_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] iReq,
  input  logic [IDX_W-1:0]   iPtr,
  output logic [NUM_REQ-1:0] oGrant,
  output logic [IDX_W-1:0]   oIdx
);

  // Scan NUM_REQ positions starting at the pointer; the first hit wins.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    oGrant = '0;
    oIdx   = '0;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'(rr_wrap(32'(iPtr) + off, NUM_REQ));
      if (!found && iReq[cand]) begin
        found        = 1'b1;
        oGrant[cand] = 1'b1;
        oIdx         = cand;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one sequential multiplier among
// NUM_REQ requesters. Latches the winner's operands, issues a one-cycle start
// pulse, waits for completion, returns the product and rotates priority.
// Optional watchdog on the wait phase: define MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = MULT_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 40
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        iReq,
  input  logic [NUM_REQ*DATA_W-1:0] iOpA,
  input  logic [NUM_REQ*DATA_W-1:0] iOpB,
  output logic [NUM_REQ-1:0]        oGrant,
  output logic [NUM_REQ-1:0]        oDone,
  output logic [2*DATA_W-1:0]       oResult,
  output logic                      oMul_Valid,
  output logic [DATA_W-1:0]         oMul_A,
  output logic [DATA_W-1:0]         oMul_B,
  input  logic                      iMul_Done,
  input  logic [2*DATA_W-1:0]       iMul_Product,
  output logic                      oMul_Ack,
  output logic                      oError
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mult_share_arbiter: parameter out of range");
  end

  arb_state_e          state_q, state_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   mul_a_q, mul_a_d;
  logic [DATA_W-1:0]   mul_b_q, mul_b_d;
  logic                ack_q, ack_d;

  logic [NUM_REQ-1:0]  pick_grant;
  logic [IdxW-1:0]     pick_idx;
  logic [IdxW-1:0]     next_ptr;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] wd_q, wd_d;
  logic            err_q, err_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_pick (
    .iReq   (iReq),
    .iPtr   (ptr_q),
    .oGrant (pick_grant),
    .oIdx   (pick_idx)
  );

  // Just-served requester drops to lowest priority.
  assign next_ptr = IdxW'(rr_wrap(32'(owner_q) + 32'd1, NUM_REQ));

  // Next-state and registered-output logic; pulses default low every cycle.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    done_d   = '0;
    result_d = result_q;
    valid_d  = 1'b0;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    ack_d    = 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
    wd_d     = '0;
    err_d    = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (|iReq) begin
          state_d = ARB_ISSUE;
          owner_d = pick_idx;
          grant_d = pick_grant;
          valid_d = 1'b1;
          mul_a_d = iOpA[32'(pick_idx)*DATA_W +: DATA_W];
          mul_b_d = iOpB[32'(pick_idx)*DATA_W +: DATA_W];
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
      end
      ARB_WAIT: begin
        if (iMul_Done) begin
          result_d = iMul_Product;
          done_d   = grant_q;
          ack_d    = 1'b1;
          state_d  = ARB_RESP;
        end
`ifdef MULT_ARB_TIMEOUT_EN
        else if (wd_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the operation: result untouched, no completion pulse.
          err_d   = 1'b1;
          ack_d   = 1'b1;
          grant_d = '0;
          ptr_d   = next_ptr;
          state_d = ARB_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      ARB_RESP: begin
        grant_d = '0;
        ptr_d   = next_ptr;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d  = ARB_IDLE;
        ptr_d    = '0;
        owner_d  = '0;
        grant_d  = '0;
        result_d = '0;
        mul_a_d  = '0;
        mul_b_d  = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      mul_a_q  <= mul_a_d;
      mul_b_q  <= mul_b_d;
      ack_q    <= ack_d;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  // Watchdog counter and abort pulse; counter is zero on every wait entry.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign oError = err_q;
`else
  assign oError = 1'b0;
`endif

  assign oGrant     = grant_q;
  assign oDone      = done_q;
  assign oResult    = result_q;
  assign oMul_Valid = valid_q;
  assign oMul_A     = mul_a_q;
  assign oMul_B     = mul_b_q;
  assign oMul_Ack   = ack_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: transaction-level model checked every cycle,
// a behavioural multiplier responder, and directed scenarios with literal
// expectations.
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 40;

  logic             Clock = 1'b0;
  logic             Reset;
  logic [N-1:0]     iReq;
  logic [N*W-1:0]   iOpA, iOpB;
  logic [N-1:0]     oGrant, oDone;
  logic [2*W-1:0]   oResult;
  logic             oMul_Valid;
  logic [W-1:0]     oMul_A, oMul_B;
  logic             iMul_Done;
  logic [2*W-1:0]   iMul_Product;
  logic             oMul_Ack, oError;

  int n_checks = 0;
  int n_errors = 0;
  int mul_lat  = 33;
  bit mul_stall = 1'b0;
  int cyc = 0;

  logic [N-1:0] grant_log[$];
  int           valid_cyc[$];
  int           done_cyc[$];

  // Model state (transaction view)
  int             m_owner = -1;
  bit             m_issue, m_wait, m_resp;
  int             m_ptr, m_wcnt;
  logic [W-1:0]   m_a, m_b;
  logic [2*W-1:0] m_result;
  bit             m_done_p, m_ack_p, m_err_p;

  mult_share_arbiter dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iReq         (iReq),
    .iOpA         (iOpA),
    .iOpB         (iOpB),
    .oGrant       (oGrant),
    .oDone        (oDone),
    .oResult      (oResult),
    .oMul_Valid   (oMul_Valid),
    .oMul_A       (oMul_A),
    .oMul_B       (oMul_B),
    .iMul_Done    (iMul_Done),
    .iMul_Product (iMul_Product),
    .oMul_Ack     (oMul_Ack),
    .oError       (oError)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s actual=no-event required=event t=%0t", name, $time);
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    if (k >= 0) v[k] = 1'b1;
    return v;
  endfunction

  // One clock edge of the model, from the inputs present at that edge.
  task automatic model_step();
    m_done_p = 1'b0;
    m_ack_p  = 1'b0;
    m_err_p  = 1'b0;
    if (Reset) begin
      m_owner = -1; m_issue = 0; m_wait = 0; m_resp = 0;
      m_ptr = 0; m_a = '0; m_b = '0; m_result = '0;
    end else if (m_resp) begin
      m_resp  = 0;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (m_issue) begin
      m_issue = 0;
      m_wait  = 1;
      m_wcnt  = 0;
    end else if (m_wait) begin
      if (iMul_Done) begin
        m_result = iMul_Product;
        m_wait   = 0;
        m_resp   = 1;
        m_done_p = 1;
        m_ack_p  = 1;
      end
`ifdef MULT_ARB_TIMEOUT_EN
      else begin
        m_wcnt++;
        if (m_wcnt == TO) begin
          m_err_p = 1; m_ack_p = 1; m_wait = 0;
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end
      end
`endif
    end else if (iReq != '0) begin
      for (int off = 0; off < N; off++) begin
        int k;
        k = (m_ptr + off) % N;
        if (m_owner < 0 && iReq[k]) begin
          m_owner = k;
          m_a     = iOpA[k*W +: W];
          m_b     = iOpB[k*W +: W];
          m_issue = 1;
        end
      end
    end
  endtask

  // Compare process: model vs DUT every cycle, plus event logging.
  initial begin
    forever begin
      @(posedge Clock);
      model_step();
      @(negedge Clock);
      #1;
      cyc++;
      check("grant",  oGrant,     onehot(m_owner));
      check("valid",  oMul_Valid, m_issue);
      check("done",   oDone,      m_done_p ? onehot(m_owner) : '0);
      check("ack",    oMul_Ack,   m_ack_p);
      check("error",  oError,     m_err_p);
      check("mul_a",  oMul_A,     m_a);
      check("mul_b",  oMul_B,     m_b);
      check("result", oResult,    m_result);
      if (oMul_Valid) begin
        grant_log.push_back(oGrant);
        valid_cyc.push_back(cyc);
      end
      if (oDone != '0) done_cyc.push_back(cyc);
    end
  end

  // Behavioural multiplier: done mul_lat cycles after the start pulse, held to ack.
  initial begin
    int cnt;
    bit busy;
    iMul_Done = 1'b0; iMul_Product = '0; busy = 0; cnt = 0;
    forever begin
      @(negedge Clock);
      #1;
      if (Reset) begin
        iMul_Done = 1'b0; busy = 0;
      end else if (iMul_Done) begin
        if (oMul_Ack) iMul_Done = 1'b0;
      end else if (oMul_Valid) begin
        busy = 1; cnt = mul_lat;
      end else if (busy && !mul_stall) begin
        if (cnt > 1) cnt--;
        else begin
          iMul_Done    = 1'b1;
          iMul_Product = 64'(oMul_A) * 64'(oMul_B);
          busy         = 0;
        end
      end
    end
  end

  task automatic set_op(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    iOpA[k*W +: W] = a;
    iOpB[k*W +: W] = b;
  endtask

  task automatic wait_done(input int bound);
    int i;
    i = 0;
    while (oDone == '0 && i < bound) begin @(negedge Clock); i++; end
    if (oDone == '0) fail_bound("wait_done");
  endtask

  task automatic wait_valid(input int bound);
    int i;
    i = 0;
    while (!oMul_Valid && i < bound) begin @(negedge Clock); i++; end
    if (!oMul_Valid) fail_bound("wait_valid");
  endtask

  task automatic clear_logs();
    grant_log.delete(); valid_cyc.delete(); done_cyc.delete();
  endtask

  initial begin
    logic [N-1:0] exp_order [5];
    int nd;
    int ecnt;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    Reset = 1'b1; iReq = '0; iOpA = '0; iOpB = '0;
    repeat (3) @(negedge Clock);
    check("rst_grant", oGrant, 4'b0000);
    check("rst_valid", oMul_Valid, 1'b0);
    check("rst_result", oResult, 64'd0);
    check("rst_mul_a", oMul_A, 32'd0);

    // Single request
    Reset = 1'b0; set_op(0, 32'd7, 32'd6); iReq = 4'b0001;
    @(negedge Clock);
    check("t1_grant", oGrant, 4'b0001);
    check("t1_valid", oMul_Valid, 1'b1);
    check("t1_a", oMul_A, 32'd7);
    check("t1_b", oMul_B, 32'd6);
    @(negedge Clock);
    check("t1_valid_drop", oMul_Valid, 1'b0);
    wait_done(100);
    check("t1_done", oDone, 4'b0001);
    check("t1_ack", oMul_Ack, 1'b1);
    check("t1_result", oResult, 64'd42);
    iReq = '0;
    @(negedge Clock);
    check("t1_grant_clr", oGrant, 4'b0000);
    check("t1_done_clr", oDone, 4'b0000);

    // Pointer is 1: requester 1 beats requester 0
    mul_lat = 2; set_op(1, 32'd3, 32'd4); iReq = 4'b0011;
    wait_valid(10);
    check("ptr1_grant", oGrant, 4'b0010);
    wait_done(50);
    check("ptr1_result", oResult, 64'd12);
    iReq = '0;
    @(negedge Clock);

    // Contention from a fresh reset
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    for (int k = 0; k < N; k++) set_op(k, 32'(100 + k), 32'd1);
    clear_logs();
    iReq = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(60);
      check("cont_done", oDone, exp_order[j]);
      check("cont_result", oResult, 64'(100 + (j % 4)));
      if (j == 4) iReq = '0;
      @(negedge Clock);
    end
    check("cont_nlog", grant_log.size(), 5);
    if (grant_log.size() == 5 && valid_cyc.size() == 5 && done_cyc.size() == 5) begin
      for (int j = 0; j < 5; j++) check("cont_order", grant_log[j], exp_order[j]);
      for (int j = 0; j < 4; j++) check("cont_gap", valid_cyc[j+1] - done_cyc[j], 2);
    end

    // Fairness after wrap: serve 2 so pointer is 3, then 1001
    set_op(2, 32'd2, 32'd2); iReq = 4'b0100;
    wait_done(60);
    check("wrap_pre_result", oResult, 64'd4);
    iReq = '0;
    @(negedge Clock);
    clear_logs();
    set_op(0, 32'd9, 32'd9); set_op(3, 32'd8, 32'd8); iReq = 4'b1001;
    wait_done(60);
    check("wrap_done3", oDone, 4'b1000);
    check("wrap_res3", oResult, 64'd64);
    iReq = 4'b0001;
    @(negedge Clock);
    wait_done(60);
    check("wrap_done0", oDone, 4'b0001);
    check("wrap_res0", oResult, 64'd81);
    iReq = '0;
    @(negedge Clock);
    check("wrap_nlog", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("wrap_first", grant_log[0], 4'b1000);
      check("wrap_second", grant_log[1], 4'b0001);
    end

    // Operand stability and request drop
    mul_lat = 10; set_op(2, 32'h1234, 32'h10); iReq = 4'b0100;
    wait_valid(10);
    check("stab_a_grant", oMul_A, 32'h1234);
    iOpA[2*W +: W] = 32'hFFFF_FFFF; iReq = '0;
    @(negedge Clock);
    @(negedge Clock);
    check("stab_a_hold", oMul_A, 32'h1234);
    check("stab_grant_hold", oGrant, 4'b0100);
    wait_done(60);
    check("stab_done", oDone, 4'b0100);
    check("stab_result", oResult, 64'h12340);
    @(negedge Clock);

    // Full 64-bit product copy
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); iReq = 4'b0001;
    wait_done(60);
    check("full_result", oResult, 64'hFFFF_FFFE_0000_0001);
    iReq = '0;
    @(negedge Clock);

    // Reset while waiting
    mul_lat = 33; set_op(1, 32'd5, 32'd5); iReq = 4'b0010;
    wait_valid(10);
    repeat (3) @(negedge Clock);
    check("mid_grant", oGrant, 4'b0010);
    Reset = 1'b1;
    @(negedge Clock);
    check("mid_rst_grant", oGrant, 4'b0000);
    check("mid_rst_a", oMul_A, 32'd0);
    check("mid_rst_result", oResult, 64'd0);
    check("mid_rst_ack", oMul_Ack, 1'b0);
    Reset = 1'b0; iReq = '0;
    nd = 0;
    repeat (45) begin
      @(negedge Clock);
      if (oDone != '0) nd++;
    end
    check("mid_no_done", nd, 0);
    mul_lat = 2; set_op(0, 32'd2, 32'd3); set_op(1, 32'd4, 32'd5); iReq = 4'b0011;
    wait_valid(10);
    check("mid_ptr0_grant", oGrant, 4'b0001);
    wait_done(50);
    check("mid_ptr0_result", oResult, 64'd6);
    iReq = '0;
    @(negedge Clock);

`ifdef MULT_ARB_TIMEOUT_EN
    // Watchdog: pointer is 1, requester 1 granted and never completed
    mul_stall = 1'b1; set_op(1, 32'd7, 32'd7); iReq = 4'b0011;
    wait_valid(10);
    check("to_grant", oGrant, 4'b0010);
    ecnt = 0;
    while (!oError && ecnt < 80) begin @(negedge Clock); ecnt++; end
    if (!oError) fail_bound("to_wait_error");
    else begin
      check("to_cycles", ecnt, TO + 1);
      check("to_ack", oMul_Ack, 1'b1);
      check("to_done", oDone, 4'b0000);
      check("to_result", oResult, 64'd6);
      check("to_grant_clr", oGrant, 4'b0000);
    end
    mul_stall = 1'b0;
    wait_valid(10);
    check("to_next_grant", oGrant, 4'b0001);
    wait_done(50);
    iReq = '0;
    @(negedge Clock);
`else
    ecnt = 0;
`endif

    repeat (3) @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    n_checks++;
    n_errors++;
    $display("FAIL global_timeout actual=running required=finished t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Round-robin arbiter and sequencer that shares one sequential shift-add multiplier (32x32 to 64) among NUM_REQ requesters. It latches the winning requester's operands and issues a single valid pulse to the multiplier control machine. It waits for completion, returns the product to the winner, acknowledges the multiplier and rotates priority. It sits between the client blocks and the multiplier datapath/control pair.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 32, operand width; product is 2*DATA_W
TIMEOUT_CYCLES, 40, watchdog limit in cycles; used only with MULT_ARB_TIMEOUT_EN

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
iReq  in  NUM_REQ  per-requester request level; held until matching oDone
iOpA  in  NUM_REQ*DATA_W  packed operand A, requester k at bits [k*DATA_W +: DATA_W]
iOpB  in  NUM_REQ*DATA_W  packed operand B, same packing
oGrant  out  NUM_REQ  one-hot owner of the multiplier; zero when idle
oDone  out  NUM_REQ  one-hot, one-cycle completion pulse to the owner
oResult  out  2*DATA_W  product; valid in the oDone cycle and held until the next oDone
oMul_Valid  out  1  one-cycle start pulse to the multiplier
oMul_A  out  DATA_W  latched operand A
oMul_B  out  DATA_W  latched operand B
iMul_Done  in  1  multiplier finished; level, held until oMul_Ack
iMul_Product  in  2*DATA_W  multiplier product, valid while iMul_Done
oMul_Ack  out  1  one-cycle acknowledge that returns the multiplier to idle
oError  out  1  one-cycle abort pulse (MULT_ARB_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Reset: all outputs are driven 0. The state is ARB_IDLE, the priority pointer is 0, and the operand latches are 0. The Reset takes effect mid-operation with no result delivered. The multiplier shares the same Reset.
- All outputs are registered.
- ARB_IDLE
  - When any iReq is set, select the first set bit searching from the pointer upward, wrapping modulo NUM_REQ.
  - At the next edge: latch that requester's iOpA and iOpB into oMul_A and oMul_B, set oGrant one-hot, assert oMul_Valid, and go to ARB_ISSUE.
- ARB_ISSUE: lasts exactly one cycle, with oMul_Valid=1. At the next edge, drop oMul_Valid and go to ARB_WAIT.
- ARB_WAIT
  - Hold oGrant and the operands.
  - When iMul_Done=1: capture iMul_Product into oResult, pulse oDone[owner] and oMul_Ack for one cycle, and go to ARB_RESP.
- ARB_RESP: lasts one cycle.
  - Pointer becomes owner+1 modulo NUM_REQ.
  - oGrant is cleared.
  - Go to ARB_IDLE.
  - A new grant is issued no earlier than the next cycle, giving a 1-cycle turnaround gap.
- Latency: iReq sampled at edge N gives oMul_Valid high during cycle N+1. iMul_Done sampled at edge M gives oDone high during cycle M+1.
- Simultaneous requests: the round-robin order from the pointer decides. A requester that has just been served has the lowest priority next.
- Operands are sampled only at grant. Changes to iOpA/iOpB afterwards are ignored.
- If iReq[owner] drops mid-operation, the operation still completes and oDone still pulses. The requester must ignore it.
- iMul_Done in ARB_IDLE or ARB_ISSUE is ignored.
- An unknown state code recovers to ARB_IDLE with outputs 0.
- No arithmetic is performed here. oResult is a straight copy of the full 2*DATA_W product.

Optional Feature:
MULT_ARB_TIMEOUT_EN
- Defined:
  - A 6-bit (clog2-sized) watchdog counts cycles spent in ARB_WAIT.
  - If the count reaches TIMEOUT_CYCLES without iMul_Done: pulse oError and oMul_Ack for one cycle, clear oGrant, leave oResult unchanged, do not pulse oDone, advance the pointer, return to ARB_IDLE.
  - The counter clears on every entry to ARB_WAIT.
- Undefined: no counter; ARB_WAIT waits indefinitely; oError is constant 0.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding constants ARB_IDLE=0, ARB_ISSUE=1, ARB_WAIT=2, ARB_RESP=3;
  - the default DATA_W=32.
- One sub-module, rr_pick:
  - purely combinational;
  - inputs: iReq and the pointer;
  - outputs: one-hot winner and index.
- The FSM and latches stay in the top.

Test Plan:
- Single request: Reset, then iReq=0001, A=7, B=6. Expect oGrant=0001 and oMul_Valid for 1 cycle with oMul_A=7, oMul_B=6. Model iMul_Done after 33 cycles with product 42. Expect oResult=42, oDone=0001 and oMul_Ack for 1 cycle, then pointer=1.
- Contention: iReq=1111 held, products k+100. Expect grants in order 0001, 0010, 0100, 1000, 0001. Each oDone matches the grant, and there is a 1-cycle gap between oDone and the next oMul_Valid.
- Fairness after wrap: pointer=3 and iReq=1001. Expect a grant to requester 3 and then to requester 0.
- Operand stability and request drop: after the grant, change iOpA to 0xFFFFFFFF and drop iReq. Expect oMul_A unchanged and oDone still pulsed with the product of the original operands. Also drive 0xFFFFFFFF x 0xFFFFFFFF and expect the full 64-bit 0xFFFFFFFE00000001.
- Reset mid-op: assert Reset in ARB_WAIT. Next cycle expect all outputs 0, state ARB_IDLE, pointer 0, and no oDone.
- Timeout (MULT_ARB_TIMEOUT_EN): withhold iMul_Done. At cycle 40 in ARB_WAIT expect oError=1 and oMul_Ack=1, oDone=0, oResult unchanged. Then a new grant to the next requester.
